serial_sub: RTL
===============

# serial_sub

Bit-serial N-bit subtractor, the subtract-direction counterpart of the team's full-adder cell. It computes diff = a − b one bit per clock, LSB first, using a single full-subtractor slice and a registered borrow. It serves as a low-area arithmetic unit in the datapath, driven by a start/done handshake from a controller.

## Interface
- N, default 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request pulse. Sampled only when busy = 0.
- a  input  N  minuend. Sampled on the accepting edge only.
- b  input  N  subtrahend. Sampled on the accepting edge only.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse marking that results are valid.
- diff  output  N  result, (a − b) mod 2^N.
- b_out  output  1  final borrow; 1 when a < b as unsigned values.

## Operation
- State machine with two states, IDLE and RUN.
- Internal registers:
  - sa, sb: N-bit shift registers.
  - sd: N-bit result shift register.
  - bin: borrow flip-flop.
  - cnt: ceil(log2(N+1))-bit counter.
- IDLE, with start = 1 at a clock edge:
  - sa ← a, sb ← b, bin ← 0, cnt ← 0.
  - State → RUN.
- RUN, at each edge:
  - Per-bit slice: d = sa[0] ^ sb[0] ^ bin; bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin).
  - sd ← {d, sd[N-1:1]}; sa and sb shift right by 1; bin ← bo; cnt ← cnt + 1.
  - When cnt = N−1, this is the last bit:
    - diff ← {d, sd[N-1:1]}, b_out ← bo.
    - done ← 1; state → IDLE.
- diff and b_out hold their values until the final edge of the next operation. They never show partial results.
- start while busy = 1 is ignored. It is neither queued nor restarts the operation.
- Borrow semantics: unsigned compare. a = b gives diff = 0 and b_out = 0.
- Reset mid-operation: the operation is aborted and all state and outputs return to their reset values. No done is produced.

## Timing
- Reset values:
  - busy = 0, done = 0, diff = 0, b_out = 0.
  - state = IDLE, cnt = 0, bin = 0.
- E0 is the edge that accepts start.
  - busy = 1 from after E0 through the cycle before EN.
  - Edges E1..EN process bits 0..N−1.
- After EN:
  - diff and b_out are updated.
  - done = 1 for exactly one cycle.
  - busy = 0.
- Latency: N cycles from the accepting edge to done.
- Throughput: back-to-back operation is allowed. start sampled at the edge that ends the done cycle (busy = 0) is accepted. That edge also clears done. Sustained rate is one result per N+1 cycles.
- done is registered and never asserted together with busy.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Adds output port ovf, 1 bit, reset 0.
  - ovf is the signed two's-complement overflow of a − b: (a[N-1] ≠ b[N-1]) && (diff[N-1] ≠ a[N-1]).
  - ovf is updated on the same edge as diff and held with it.
  - The operand sign bits are captured on the accepting edge.
- SERIAL_SUB_OVF_EN not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use N = 8.
- Basic difference: a=0x05, b=0x03, start one cycle -> done exactly 8 cycles after the accepting edge, diff=0x02, b_out=0, busy high for 8 cycles.
- Borrow: a=0x03, b=0x05 -> diff=0xFE, b_out=1. With the macro, ovf=0. Also a=0x00, b=0x00 -> diff=0x00, b_out=0.
- Signed overflow (macro on): a=0x80, b=0x01 -> diff=0x7F, b_out=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, b_out=1, ovf=1.
- Start while busy: a=0x10, b=0x01 accepted; 3 cycles later start with a=0xFF, b=0xFF -> ignored, result diff=0x0F, single done pulse.
- Back-to-back: start held high across the done cycle with a=0x20, b=0x10, then a=0x10, b=0x20 -> diff=0x10, b_out=0, then 9 cycles later diff=0xF0, b_out=1.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 4 of a run -> busy, done, diff and b_out go to 0 immediately, no done after release. A new start after release completes normally.

Source files
------------

// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bundle for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, a, b, input busy, done, diff, b_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, b_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, b_out);
  modport slave  (input start, a, b, output busy, done, diff, b_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: one full-subtractor slice, LSB first, registered borrow.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bin_q, bin_d, bout_q, bout_d, done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            d_bit, bo_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic            as_q, as_d, bs_q, bs_d, ovf_q, ovf_d;
`endif

  assign d_bit  = sa_q[0] ^ sb_q[0] ^ bin_q;
  assign bo_bit = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bin_q);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    as_d    = as_q;
    bs_d    = bs_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          as_d    = bus.a[N-1];
          bs_d    = bus.b[N-1];
`endif
        end
      end
      RUN: begin
        sd_d  = {d_bit, sd_q[N-1:1]};
        sa_d  = {1'b0, sa_q[N-1:1]};
        sb_d  = {1'b0, sb_q[N-1:1]};
        bin_d = bo_bit;
        cnt_d = cnt_q + CW'(1);
        // Results are published only on the last bit so diff never shows partial values.
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = {d_bit, sd_q[N-1:1]};
          bout_d  = bo_bit;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (as_q != bs_q) && (d_bit != as_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      bin_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      as_q    <= as_d;
      bs_q    <= bs_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
